// File: rtl/dmux_router.sv
// Registered 1-to-CHANNELS stream router with per-channel one-entry output slots and valid/ready.
// Optional delivery/drop counters are built when DMUX_ROUTER_CNT_EN is defined.
module dmux_router #(
    parameter int WIDTH     = 1,
    parameter int CHANNELS  = 4,
    parameter int SEL_W     = 2,
    parameter int ZERO_IDLE = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic [SEL_W-1:0]             in_sel,
    output logic [CHANNELS-1:0]          out_valid,
    input  logic [CHANNELS-1:0]          out_ready,
    output logic [CHANNELS*WIDTH-1:0]    out_data,
    output logic                         err_sel
`ifdef DMUX_ROUTER_CNT_EN
    ,
    output logic [CHANNELS*16-1:0]       chan_cnt,
    output logic [15:0]                  drop_cnt
`endif
);

    localparam logic [SEL_W:0] CH_LIMIT = (SEL_W+1)'(CHANNELS);

    logic                      sel_ok;
    logic [CHANNELS-1:0]       hit;
    logic [CHANNELS-1:0]       load;
    logic [CHANNELS-1:0]       drain;
    logic [CHANNELS-1:0]       valid_q, valid_d;
    logic [CHANNELS*WIDTH-1:0] data_q, data_d;
    logic                      err_q, err_d;

    always_comb begin
        sel_ok = ({1'b0, in_sel} < CH_LIMIT);
        hit    = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            hit[k] = sel_ok && (in_sel == SEL_W'(k));
        end
        // Out-of-range words are always taken so they can be dropped and flagged.
        in_ready = sel_ok ? |(hit & (~valid_q | out_ready)) : 1'b1;
        drain    = valid_q & out_ready;
    end

    always_comb begin
        load    = (in_valid && in_ready) ? hit : '0;
        valid_d = valid_q;
        data_d  = data_q;
        for (int k = 0; k < CHANNELS; k++) begin
            if (load[k]) begin
                valid_d[k]                = 1'b1;
                data_d[k*WIDTH +: WIDTH]  = in_data;
            end else if (drain[k]) begin
                valid_d[k] = 1'b0;
                if (ZERO_IDLE != 0) begin
                    data_d[k*WIDTH +: WIDTH] = '0;
                end
            end
        end
        err_d = in_valid && !sel_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign err_sel   = err_q;

`ifdef DMUX_ROUTER_CNT_EN
    logic [15:0] cnt_q [CHANNELS];
    logic [15:0] cnt_d [CHANNELS];
    logic [15:0] drop_q, drop_d;

    // Counters saturate rather than wrap so a stuck consumer is still visible.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            cnt_d[k] = cnt_q[k];
            if (drain[k] && (cnt_q[k] != 16'hFFFF)) begin
                cnt_d[k] = cnt_q[k] + 16'd1;
            end
        end
        drop_d = drop_q;
        if (err_d && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CHANNELS; k++) begin
                cnt_q[k] <= '0;
            end
            drop_q <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            drop_q <= drop_d;
        end
    end

    always_comb begin
        chan_cnt = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            chan_cnt[k*16 +: 16] = cnt_q[k];
        end
    end

    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_dmux_router.sv
// Bench for dmux_router: a 4-channel zero-idle instance and a 3-channel hold-mode instance,
// with per-channel scoreboards checking every delivered word.
module tb_dmux_router;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic        a_in_valid, a_in_ready;
    logic [7:0]  a_in_data;
    logic [1:0]  a_in_sel;
    logic [3:0]  a_out_valid, a_out_ready;
    logic [31:0] a_out_data;
    logic        a_err;

    logic        b_in_valid, b_in_ready;
    logic [7:0]  b_in_data;
    logic [1:0]  b_in_sel;
    logic [2:0]  b_out_valid, b_out_ready;
    logic [23:0] b_out_data;
    logic        b_err;

`ifdef DMUX_ROUTER_CNT_EN
    logic [63:0] a_chan_cnt;
    logic [15:0] a_drop_cnt;
    logic [47:0] b_chan_cnt;
    logic [15:0] b_drop_cnt;
`endif

    dmux_router #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .ZERO_IDLE(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_sel(a_in_sel),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .err_sel(a_err)
`ifdef DMUX_ROUTER_CNT_EN
        , .chan_cnt(a_chan_cnt), .drop_cnt(a_drop_cnt)
`endif
    );

    dmux_router #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .ZERO_IDLE(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_sel(b_in_sel),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .err_sel(b_err)
`ifdef DMUX_ROUTER_CNT_EN
        , .chan_cnt(b_chan_cnt), .drop_cnt(b_drop_cnt)
`endif
    );

    logic [7:0] qa [4][$];
    logic [7:0] qb [3][$];
    logic [7:0] exp_w;

    // Scoreboard: pop on every drain, push on every in-range accept (pop first: a word
    // pushed this cycle cannot be drained before the next edge).
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (a_out_valid[k] && a_out_ready[k]) begin
                    checks++;
                    if (qa[k].size() == 0) begin
                        errors++;
                        $display("FAIL sb_a ch%0d unexpected word got %h expected none", k, a_out_data[k*8 +: 8]);
                    end else begin
                        exp_w = qa[k].pop_front();
                        if (a_out_data[k*8 +: 8] !== exp_w) begin
                            errors++;
                            $display("FAIL sb_a ch%0d got %h expected %h", k, a_out_data[k*8 +: 8], exp_w);
                        end
                    end
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (b_out_valid[k] && b_out_ready[k]) begin
                    checks++;
                    if (qb[k].size() == 0) begin
                        errors++;
                        $display("FAIL sb_b ch%0d unexpected word got %h expected none", k, b_out_data[k*8 +: 8]);
                    end else begin
                        exp_w = qb[k].pop_front();
                        if (b_out_data[k*8 +: 8] !== exp_w) begin
                            errors++;
                            $display("FAIL sb_b ch%0d got %h expected %h", k, b_out_data[k*8 +: 8], exp_w);
                        end
                    end
                end
            end
            if (a_in_valid && a_in_ready) qa[a_in_sel].push_back(a_in_data);
            if (b_in_valid && b_in_ready && (b_in_sel != 2'd3)) qb[b_in_sel].push_back(b_in_data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_init();
        rst_n = 1'b0;
        a_in_valid = 0; a_in_data = 0; a_in_sel = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = 0; b_in_sel = 0; b_out_ready = 0;
        repeat (3) cyc();
        checks++;
        if (a_out_valid !== 4'b0 || a_out_data !== 32'h0 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL init_a valid=%b data=%h err=%b expected 0", a_out_valid, a_out_data, a_err);
        end
        checks++;
        if (b_out_valid !== 3'b0 || b_out_data !== 24'h0 || b_err !== 1'b0) begin
            errors++;
            $display("FAIL init_b valid=%b data=%h err=%b expected 0", b_out_valid, b_out_data, b_err);
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_routing();
        a_out_ready = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i > 0) begin
                checks++;
                if (a_out_valid[i-1] !== 1'b1 || a_out_data[(i-1)*8 +: 8] !== 8'hA0 + 8'(i-1)) begin
                    errors++;
                    $display("FAIL route_load ch%0d valid=%b data=%h expected 1/%h",
                             i-1, a_out_valid[i-1], a_out_data[(i-1)*8 +: 8], 8'hA0 + 8'(i-1));
                end
            end
            if (i > 1) begin
                checks++;
                if (a_out_valid[i-2] !== 1'b0 || a_out_data[(i-2)*8 +: 8] !== 8'h00) begin
                    errors++;
                    $display("FAIL route_zero ch%0d valid=%b data=%h expected 0/00",
                             i-2, a_out_valid[i-2], a_out_data[(i-2)*8 +: 8]);
                end
            end
            if (i < 4) begin
                a_in_valid = 1; a_in_data = 8'hA0 + 8'(i); a_in_sel = 2'(i);
                #1;
                checks++;
                if (a_in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL route_ready sel%0d got %b expected 1", i, a_in_ready);
                end
            end else begin
                a_in_valid = 0;
            end
        end
        cyc();
        checks++;
        if (a_out_valid !== 4'b0000 || a_out_data !== 32'h0) begin
            errors++;
            $display("FAIL route_idle valid=%b data=%h expected 0/0", a_out_valid, a_out_data);
        end
    endtask

    task automatic test_backpressure();
        a_out_ready = 4'b1101;
        cyc();
        a_in_valid = 1; a_in_data = 8'h11; a_in_sel = 2'd1;
        #1;
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_first_ready got %b expected 1", a_in_ready);
        end
        cyc();
        a_in_data = 8'h22;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (a_in_ready !== 1'b0 || a_out_valid[1] !== 1'b1 || a_out_data[15:8] !== 8'h11) begin
                errors++;
                $display("FAIL bp_stall cyc%0d ready=%b valid=%b data=%h expected 0/1/11",
                         i, a_in_ready, a_out_valid[1], a_out_data[15:8]);
            end
            if (i < 2) cyc();
        end
        a_out_ready[1] = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready got %b expected 1", a_in_ready);
        end
        cyc();
        a_in_valid = 0;
        a_out_ready[1] = 1'b0;
        checks++;
        if (a_out_valid[1] !== 1'b1 || a_out_data[15:8] !== 8'h22) begin
            errors++;
            $display("FAIL bp_no_gap valid=%b data=%h expected 1/22", a_out_valid[1], a_out_data[15:8]);
        end
    endtask

    task automatic test_independence();
        a_out_ready = 4'b0101;
        cyc();
        a_in_valid = 1; a_in_data = 8'h33; a_in_sel = 2'd3;
        #1;
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ind_ready got %b expected 1", a_in_ready);
        end
        cyc();
        a_in_valid = 0;
        checks++;
        if (a_out_valid !== 4'b1010 || a_out_data[31:24] !== 8'h33 || a_out_data[15:8] !== 8'h22) begin
            errors++;
            $display("FAIL ind_state valid=%b ch3=%h ch1=%h expected 1010/33/22",
                     a_out_valid, a_out_data[31:24], a_out_data[15:8]);
        end
        a_out_ready = 4'b1111;
        cyc();
        checks++;
        if (a_out_valid !== 4'b0000 || a_out_data !== 32'h0) begin
            errors++;
            $display("FAIL ind_drain valid=%b data=%h expected 0/0", a_out_valid, a_out_data);
        end
        checks++;
        if (qa[0].size() + qa[1].size() + qa[2].size() + qa[3].size() != 0) begin
            errors++;
            $display("FAIL sb_a_leftover got %0d words expected 0",
                     qa[0].size() + qa[1].size() + qa[2].size() + qa[3].size());
        end
    endtask

    task automatic test_bad_select();
        b_out_ready = 3'b000;
        cyc();
        b_in_sel = 2'd3; b_in_data = 8'h55; b_in_valid = 0;
        #1;
        checks++;
        if (b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bad_ready_novalid got %b expected 1", b_in_ready);
        end
        b_in_valid = 1;
        #1;
        checks++;
        if (b_in_ready !== 1'b1 || b_err !== 1'b0) begin
            errors++;
            $display("FAIL bad_accept ready=%b err=%b expected 1/0", b_in_ready, b_err);
        end
        cyc();
        b_in_valid = 0;
        checks++;
        if (b_err !== 1'b1 || b_out_valid !== 3'b000) begin
            errors++;
            $display("FAIL bad_pulse err=%b valid=%b expected 1/000", b_err, b_out_valid);
        end
`ifdef DMUX_ROUTER_CNT_EN
        checks++;
        if (b_drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL bad_drop_cnt got %0d expected 1", b_drop_cnt);
        end
`endif
        cyc();
        checks++;
        if (b_err !== 1'b0 || b_out_valid !== 3'b000) begin
            errors++;
            $display("FAIL bad_pulse_end err=%b valid=%b expected 0/000", b_err, b_out_valid);
        end
    endtask

    task automatic test_hold_mode();
        b_out_ready = 3'b000;
        cyc();
        b_in_valid = 1; b_in_data = 8'h7E; b_in_sel = 2'd0;
        cyc();
        b_in_valid = 0;
        checks++;
        if (b_out_valid[0] !== 1'b1 || b_out_data[7:0] !== 8'h7E) begin
            errors++;
            $display("FAIL hold_load valid=%b data=%h expected 1/7e", b_out_valid[0], b_out_data[7:0]);
        end
        b_out_ready = 3'b001;
        cyc();
        b_out_ready = 3'b000;
        checks++;
        if (b_out_valid[0] !== 1'b0 || b_out_data[7:0] !== 8'h7E) begin
            errors++;
            $display("FAIL hold_keep valid=%b data=%h expected 0/7e", b_out_valid[0], b_out_data[7:0]);
        end
`ifdef DMUX_ROUTER_CNT_EN
        checks++;
        if (b_chan_cnt[15:0] !== 16'd1) begin
            errors++;
            $display("FAIL hold_chan_cnt got %0d expected 1", b_chan_cnt[15:0]);
        end
`endif
    endtask

    task automatic test_reset();
        a_out_ready = 4'b0000;
        cyc();
        a_in_valid = 1; a_in_data = 8'hC2; a_in_sel = 2'd2;
        b_in_valid = 1; b_in_data = 8'h99; b_in_sel = 2'd3;
        cyc();
        a_in_valid = 0; b_in_valid = 0;
        checks++;
        if (a_out_valid !== 4'b0100 || b_err !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre a_valid=%b b_err=%b expected 0100/1", a_out_valid, b_err);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 4'b0 || a_out_data !== 32'h0 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_async_a valid=%b data=%h err=%b expected 0", a_out_valid, a_out_data, a_err);
        end
        checks++;
        if (b_out_valid !== 3'b0 || b_out_data !== 24'h0 || b_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_async_b valid=%b data=%h err=%b expected 0", b_out_valid, b_out_data, b_err);
        end
`ifdef DMUX_ROUTER_CNT_EN
        checks++;
        if (a_chan_cnt !== 64'h0 || b_chan_cnt !== 48'h0 || b_drop_cnt !== 16'h0) begin
            errors++;
            $display("FAIL rst_cnt a=%h b=%h drop=%0d expected 0", a_chan_cnt, b_chan_cnt, b_drop_cnt);
        end
`endif
        for (int k = 0; k < 4; k++) qa[k].delete();
        for (int k = 0; k < 3; k++) qb[k].delete();
        cyc();
        rst_n = 1'b1;
        a_out_ready = 4'b1111;
        repeat (2) cyc();
        checks++;
        if (a_out_valid !== 4'b0 || a_out_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_after valid=%b data=%h expected 0/0", a_out_valid, a_out_data);
        end
    endtask

    initial begin
        test_init();
        test_routing();
        test_backpressure();
        test_independence();
        test_bad_select();
        test_hold_mode();
        test_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
